// File: rtl/keccak_padder_p_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keccak_padder_p_if : host word stream in, padded rate block out            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface keccak_padder_p_if #(
  parameter int IN_W = 32,
  parameter int RATE = 576
);
  logic [IN_W-1:0]               in;
  logic                          in_ready;
  logic                          is_last;
  logic [$clog2(IN_W/8)-1:0]     byte_num;
  logic                          f_ack;
  logic                          buffer_full;
  logic [RATE-1:0]               out;
  logic                          out_ready;
  logic                          last_block;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, last_block
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, last_block
  );
endinterface
`default_nettype wire

// File: rtl/keccak_padder_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keccak_padder_p : packs words into RATE-bit blocks with multi-rate padding |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module keccak_padder_p #(
  parameter int         IN_W   = 32,
  parameter int         RATE   = 576,
  parameter logic [7:0] DOMAIN = 8'h01
) (
  input  wire logic       clk,
  input  wire logic       reset,
  keccak_padder_p_if.slave bus
);

  localparam int c_bytes = IN_W / 8;
  localparam int c_words = RATE / IN_W;
  localparam int c_cnt_w = $clog2(c_words + 1);
  localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(c_words - 1);

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PAD    = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pad_pending;
  logic [RATE-1:0]    r_out;
  logic               r_out_ready;
  logic               r_last_block;
  logic               r_buffer_full;

  logic [IN_W-1:0]    w_last_word;
  logic [IN_W-1:0]    w_pad_word;
  logic [IN_W-1:0]    w_in_word;
  logic               w_final_slot;

  assign w_final_slot = (r_cnt == c_last_slot);

  // Byte 0 sits in the MSBs; the 0x80 terminator always lands in the block's last byte.
  always_comb begin
    w_last_word = '0;
    for (int b = 0; b < c_bytes; b++) begin
      if (b < int'(bus.byte_num))
        w_last_word[IN_W-1-8*b -: 8] = bus.in[IN_W-1-8*b -: 8];
      else if (b == int'(bus.byte_num))
        w_last_word[IN_W-1-8*b -: 8] = DOMAIN;
    end
    if (w_final_slot)
      w_last_word[7:0] = w_last_word[7:0] | 8'h80;
  end

  always_comb begin
    w_pad_word = '0;
    if (w_final_slot)
      w_pad_word[7:0] = 8'h80;
  end

  assign w_in_word = bus.is_last ? w_last_word : bus.in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ABSORB;
      r_cnt         <= '0;
      r_pad_pending <= 1'b0;
      r_out         <= '0;
      r_out_ready   <= 1'b0;
      r_last_block  <= 1'b0;
      r_buffer_full <= 1'b0;
    end else begin
      case (r_state)
        ST_ABSORB: begin
          if (bus.in_ready) begin
            r_out <= {r_out[RATE-IN_W-1:0], w_in_word};
            r_cnt <= r_cnt + 1'b1;
            if (bus.is_last)
              r_pad_pending <= 1'b1;
            if (w_final_slot) begin
              r_state       <= ST_FULL;
              r_out_ready   <= 1'b1;
              r_last_block  <= bus.is_last | r_pad_pending;
              r_buffer_full <= 1'b1;
            end else if (bus.is_last) begin
              r_state       <= ST_PAD;
              r_buffer_full <= 1'b1;
            end
          end
        end
        ST_PAD: begin
          r_out <= {r_out[RATE-IN_W-1:0], w_pad_word};
          r_cnt <= r_cnt + 1'b1;
          if (w_final_slot) begin
            r_state      <= ST_FULL;
            r_out_ready  <= 1'b1;
            r_last_block <= r_pad_pending;
          end
        end
        ST_FULL: begin
          // The block stays in r_out; the next message simply shifts over it.
          if (bus.f_ack) begin
            r_state       <= ST_ABSORB;
            r_cnt         <= '0;
            r_pad_pending <= 1'b0;
            r_out_ready   <= 1'b0;
            r_last_block  <= 1'b0;
            r_buffer_full <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_ABSORB;
          r_buffer_full <= 1'b0;
          r_out_ready   <= 1'b0;
          r_last_block  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out         = r_out;
  assign bus.out_ready   = r_out_ready;
  assign bus.last_block  = r_last_block;
  assign bus.buffer_full = r_buffer_full;

endmodule
`default_nettype wire

// File: tb/tb_keccak_padder_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_keccak_padder_p : directed vectors for the 32/576 and 64/1088 padders   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_keccak_padder_p;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;
  int   n;

  keccak_padder_p_if #(.IN_W(32), .RATE(576))  ifa ();
  keccak_padder_p_if #(.IN_W(64), .RATE(1088)) ifb ();

  keccak_padder_p #(.IN_W(32), .RATE(576), .DOMAIN(8'h01)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa.slave)
  );

  keccak_padder_p #(.IN_W(64), .RATE(1088), .DOMAIN(8'h06)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wa(input int i);
    return ifa.out[575-32*i -: 32];
  endfunction

  function automatic logic [63:0] wb(input int i);
    return ifb.out[1087-64*i -: 64];
  endfunction

  task automatic put_a(input logic [31:0] d, input logic last, input logic [1:0] bn);
    ifa.in = d; ifa.in_ready = 1'b1; ifa.is_last = last; ifa.byte_num = bn;
    step();
    ifa.in_ready = 1'b0; ifa.is_last = 1'b0;
  endtask

  task automatic put_b(input logic [63:0] d, input logic last, input logic [2:0] bn);
    ifb.in = d; ifb.in_ready = 1'b1; ifb.is_last = last; ifb.byte_num = bn;
    step();
    ifb.in_ready = 1'b0; ifb.is_last = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_ready, bounded.
  task automatic wait_rdy(input bit use_b, output int cyc);
    cyc = 1;
    while (!(use_b ? ifb.out_ready : ifa.out_ready) && cyc < 64) begin
      step();
      cyc++;
    end
  endtask

  task automatic ack_a();
    ifa.f_ack = 1'b1; step(); ifa.f_ack = 1'b0;
  endtask

  task automatic ack_b();
    ifb.f_ack = 1'b1; step(); ifb.f_ack = 1'b0;
  endtask

  task automatic chk_empty_a(input string tag);
    chk({tag, "_w0"},  {32'h0, wa(0)},  64'h01000000);
    chk({tag, "_mid"}, {63'h0, |ifa.out[543:32]}, 64'h0);
    chk({tag, "_w17"}, {32'h0, wa(17)}, 64'h00000080);
    chk({tag, "_lb"},  {63'h0, ifa.last_block}, 64'h1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.in = '0; ifa.in_ready = 1'b0; ifa.is_last = 1'b0; ifa.byte_num = '0; ifa.f_ack = 1'b0;
    ifb.in = '0; ifb.in_ready = 1'b0; ifb.is_last = 1'b0; ifb.byte_num = '0; ifb.f_ack = 1'b0;
    repeat (2) step();
    chk("rst_or",  {63'h0, ifa.out_ready},   64'h0);
    chk("rst_bf",  {63'h0, ifa.buffer_full}, 64'h0);
    chk("rst_lb",  {63'h0, ifa.last_block},  64'h0);
    chk("rst_out", {63'h0, |ifa.out},        64'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // Empty message: all padding, 18 cycles to a complete block.
    put_a(32'hDEADBEEF, 1'b1, 2'd0);
    chk("e_bf", {63'h0, ifa.buffer_full}, 64'h1);
    chk("e_or", {63'h0, ifa.out_ready},   64'h0);
    wait_rdy(1'b0, n);
    chk("e_lat", 64'(n), 64'd18);
    chk_empty_a("e");
    ack_a();
    chk("e_ack_or", {63'h0, ifa.out_ready},   64'h0);
    chk("e_ack_bf", {63'h0, ifa.buffer_full}, 64'h0);

    // 17 full words + 3-byte tail in the final slot: domain and terminator share a byte.
    for (int i = 0; i < 17; i++) put_a(32'h10000000 + 32'(i), 1'b0, 2'd0);
    chk("t_nobubble", {63'h0, ifa.buffer_full}, 64'h0);
    put_a(32'hAABBCCDD, 1'b1, 2'd3);
    chk("t_or",  {63'h0, ifa.out_ready},  64'h1);
    chk("t_lb",  {63'h0, ifa.last_block}, 64'h1);
    chk("t_w0",  {32'h0, wa(0)},  64'h10000000);
    chk("t_w16", {32'h0, wa(16)}, 64'h10000010);
    chk("t_w17", {32'h0, wa(17)}, 64'hAABBCC81);
    ack_a();

    // 18 full words, then a held last word under 5 cycles of ack delay.
    for (int i = 0; i < 18; i++) put_a(32'h20000000 + 32'(i), 1'b0, 2'd0);
    chk("m_or1", {63'h0, ifa.out_ready},  64'h1);
    chk("m_lb1", {63'h0, ifa.last_block}, 64'h0);
    ifa.in = 32'h99999999; ifa.in_ready = 1'b1; ifa.is_last = 1'b1; ifa.byte_num = 2'd0;
    repeat (5) step();
    chk("m_hold_bf", {63'h0, ifa.buffer_full}, 64'h1);
    chk("m_hold_or", {63'h0, ifa.out_ready},   64'h1);
    chk("m_b1_w0",   {32'h0, wa(0)},  64'h20000000);
    chk("m_b1_w17",  {32'h0, wa(17)}, 64'h20000011);
    ifa.f_ack = 1'b1; step(); ifa.f_ack = 1'b0;
    chk("m_ack_or", {63'h0, ifa.out_ready},   64'h0);
    chk("m_ack_bf", {63'h0, ifa.buffer_full}, 64'h0);
    step();
    ifa.in_ready = 1'b0; ifa.is_last = 1'b0;
    wait_rdy(1'b0, n);
    chk("m_lat2", 64'(n), 64'd18);
    chk_empty_a("m_b2");
    ack_a();

    // Reset while padding at slot 7, then a fresh empty message.
    put_a(32'h0, 1'b1, 2'd0);
    repeat (6) step();
    rst_a = 1'b1;
    step();
    chk("r_or",  {63'h0, ifa.out_ready},   64'h0);
    chk("r_bf",  {63'h0, ifa.buffer_full}, 64'h0);
    chk("r_lb",  {63'h0, ifa.last_block},  64'h0);
    chk("r_out", {63'h0, |ifa.out},        64'h0);
    rst_a = 1'b0;
    put_a(32'h12345678, 1'b1, 2'd0);
    wait_rdy(1'b0, n);
    chk("r_lat", 64'(n), 64'd18);
    chk_empty_a("r");
    ack_a();

    // SHA-3 domain, 64-bit words, two back-to-back 3-byte messages.
    put_b(64'hA1B2C3FFFFFFFFFF, 1'b1, 3'd3);
    wait_rdy(1'b1, n);
    chk("b1_lat", 64'(n), 64'd17);
    chk("b1_w0",  wb(0),  64'hA1B2C306_00000000);
    chk("b1_mid", {63'h0, |ifb.out[1023:64]}, 64'h0);
    chk("b1_w16", wb(16), 64'h00000000_00000080);
    chk("b1_lb",  {63'h0, ifb.last_block}, 64'h1);
    ack_b();
    chk("b1_ack_bf", {63'h0, ifb.buffer_full}, 64'h0);
    put_b(64'hD4E5F6123456789A, 1'b1, 3'd3);
    wait_rdy(1'b1, n);
    chk("b2_lat", 64'(n), 64'd17);
    chk("b2_w0",  wb(0),  64'hD4E5F606_00000000);
    chk("b2_mid", {63'h0, |ifb.out[1023:64]}, 64'h0);
    chk("b2_w16", wb(16), 64'h00000000_00000080);
    chk("b2_lb",  {63'h0, ifb.last_block}, 64'h1);
    ack_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
